sdram_pll_reset_ctrl: RTL and testbench

SDRAM_PLL_RESET_CTRL -- requirements
Module: sdram_pll_reset_ctrl

---
 rtl/sdram_pll_reset_ctrl_pkg.sv | 27 ++
 rtl/sdram_pll_reset_ctrl_sync_2ff.sv | 22 ++
 rtl/sdram_pll_reset_ctrl.sv | 133 +++++++++++++
 tb/tb_sdram_pll_reset_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pll_reset_ctrl_pkg.sv
// Shared types and default timing constants for the PLL / SDRAM reset sequencer.
package sdram_pll_reset_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_SDRAM_WAIT = 3'd3,
    ST_READY      = 3'd4
  } state_t;

  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_SDRAM_PWRUP_CYCLES  = 10000;

  // Largest of the four cycle counts; sizes the shared counter.
  function automatic int max_cycles(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_pll_reset_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_reset_ctrl.sv
// Sequences PLL reset, lock qualification, core reset and SDRAM power-up reset.
// The shared counter is a down-counter that starts at zero on every state entry
// (and on reset), so each timed state ends when it reaches -(N-1).
module sdram_pll_reset_ctrl
  import sdram_pll_reset_ctrl_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int SDRAM_PWRUP_CYCLES  = DEF_SDRAM_PWRUP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       sdram_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_CYCLES = max_cycles(LOCK_STABLE_CYCLES, PLL_RST_CYCLES,
                                         LOCK_TIMEOUT_CYCLES, SDRAM_PWRUP_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_TERM     = CNT_W'(-(PLL_RST_CYCLES - 1));
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(-(LOCK_TIMEOUT_CYCLES - 1));
  localparam logic [CNT_W-1:0] STABLE_TERM  = CNT_W'(-(LOCK_STABLE_CYCLES - 1));
  localparam logic [CNT_W-1:0] PWRUP_TERM   = CNT_W'(-(SDRAM_PWRUP_CYCLES - 1));

  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       llc_d;
  logic             pll_rst_d, sys_rst_d, sdram_rst_d, ready_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, counter and registered-output decisions; lock loss outranks soft requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_ONE;
    llc_d   = lock_loss_cnt;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_TERM) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_TERM) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TERM) begin
          state_d = ST_SDRAM_WAIT;
          cnt_d   = '0;
        end
      end
      ST_SDRAM_WAIT: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          if (lock_loss_cnt != 8'hFF) llc_d = lock_loss_cnt + 8'd1;
        end else if (soft_rst_req) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == PWRUP_TERM) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          if (lock_loss_cnt != 8'hFF) llc_d = lock_loss_cnt + 8'd1;
        end else if (soft_rst_req) begin
          state_d = ST_STABLE;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d   = (state_d == ST_PLL_RST);
    sys_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                  (state_d == ST_STABLE);
    sdram_rst_d = (state_d != ST_READY);
    ready_d     = (state_d == ST_READY);
  end

  // State, counter and all outputs are flops so the reset lines never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      sdram_rst     <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst       <= pll_rst_d;
      sys_rst       <= sys_rst_d;
      sdram_rst     <= sdram_rst_d;
      ready         <= ready_d;
      lock_loss_cnt <= llc_d;
    end
  end

endmodule

// File: tb/tb_sdram_pll_reset_ctrl.sv
// Scoreboard bench: stimulus queues every expected output change (edge number
// and values); a negedge monitor pops one entry per observed change.
module tb_sdram_pll_reset_ctrl;

  localparam int STABLE_C  = 4;
  localparam int RST_C     = 16;
  localparam int TIMEOUT_C = 64;
  localparam int PWRUP_C   = 32;

  typedef struct packed {
    logic       pll;
    logic       sys;
    logic       sdr;
    logic       rdy;
    logic [7:0] llc;
  } outs_t;

  typedef struct {
    int    edge_no;
    outs_t val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       sdram_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  exp_t  exp_q[$];
  int    edge_n  = 0;
  int    checks  = 0;
  int    passes  = 0;
  int    evt_idx = 0;
  outs_t prev    = 'x;
  outs_t mon_cur;
  exp_t  mon_e;

  sdram_pll_reset_ctrl #(
    .LOCK_STABLE_CYCLES  (STABLE_C),
    .PLL_RST_CYCLES      (RST_C),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT_C),
    .SDRAM_PWRUP_CYCLES  (PWRUP_C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .sdram_rst     (sdram_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising edge seen with rst low.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic waitEdge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int at_edge, input logic r, input logic l, input logic s);
    waitEdge(at_edge);
    rst          = r;
    pll_locked   = l;
    soft_rst_req = s;
  endtask

  task automatic expectEvent(input int e, input logic p, input logic sy, input logic sd,
                             input logic rd, input logic [7:0] c);
    exp_t x;
    x.edge_no = e;
    x.val     = {p, sy, sd, rd, c};
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input exp_t e, input outs_t act);
    checks++;
    if (e.edge_no == edge_n && act === e.val) begin
      passes++;
    end else begin
      $display("[TB] FAIL event_%0d: got edge %0d pll/sys/sdr/rdy=%b%b%b%b cnt=%0d, expected edge %0d pll/sys/sdr/rdy=%b%b%b%b cnt=%0d",
               evt_idx, edge_n, act.pll, act.sys, act.sdr, act.rdy, act.llc,
               e.edge_no, e.val.pll, e.val.sys, e.val.sdr, e.val.rdy, e.val.llc);
    end
    evt_idx++;
  endtask

  // Monitor: any change of the output vector must match the next queued event.
  always @(negedge clk) begin
    mon_cur = {pll_rst, sys_rst, sdram_rst, ready, lock_loss_cnt};
    if (mon_cur !== prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_change: got edge %0d outs=%b, expected no change",
                 edge_n, mon_cur);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput(mon_e, mon_cur);
      end
      prev = mon_cur;
    end
  end

  // Directed sequence: power-up, lock loss, soft resets, glitch, timeout, saturation, async abort.
  initial begin
    int p;
    logic [7:0] llc;

    rst          = 1'b1;
    pll_locked   = 1'b1;
    soft_rst_req = 1'b0;
    expectEvent(0, 1, 1, 1, 0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Lock high from the start: 16-cycle PLL pulse, 4 stable cycles, 32-cycle power-up.
    expectEvent(16, 0, 1, 1, 0, 8'd0);
    expectEvent(21, 0, 0, 1, 0, 8'd0);
    expectEvent(53, 0, 0, 0, 1, 8'd0);

    // Lock drop in READY (seen 3 edges later through the synchronizer).
    applyStimulus(60, 0, 0, 0);
    expectEvent(63, 1, 1, 1, 0, 8'd1);

    // Relock and resequence.
    applyStimulus(70, 0, 1, 0);
    expectEvent(79, 0, 1, 1, 0, 8'd1);
    expectEvent(84, 0, 0, 1, 0, 8'd1);
    expectEvent(116, 0, 0, 0, 1, 8'd1);

    // Soft reset from READY: re-release after 4 + 32 cycles.
    applyStimulus(120, 0, 1, 1);
    expectEvent(121, 0, 1, 1, 0, 8'd1);
    expectEvent(125, 0, 0, 1, 0, 8'd1);
    expectEvent(157, 0, 0, 0, 1, 8'd1);
    applyStimulus(121, 0, 1, 0);

    // Soft reset, then a one-cycle lock glitch during STABLE delays sys_rst release.
    applyStimulus(160, 0, 1, 1);
    expectEvent(161, 0, 1, 1, 0, 8'd1);
    applyStimulus(161, 0, 1, 0);
    applyStimulus(162, 0, 0, 0);
    applyStimulus(163, 0, 1, 0);
    expectEvent(170, 0, 0, 1, 0, 8'd1);
    expectEvent(202, 0, 0, 0, 1, 8'd1);

    // Lock loss and soft request on the same edge: lock loss path wins.
    applyStimulus(210, 0, 0, 0);
    applyStimulus(212, 0, 0, 1);
    expectEvent(213, 1, 1, 1, 0, 8'd2);
    applyStimulus(213, 0, 0, 0);

    // No lock: PLL pulse retried every 16 + 64 cycles, count unchanged; soft request ignored.
    expectEvent(229, 0, 1, 1, 0, 8'd2);
    expectEvent(293, 1, 1, 1, 0, 8'd2);
    expectEvent(309, 0, 1, 1, 0, 8'd2);
    expectEvent(373, 1, 1, 1, 0, 8'd2);
    applyStimulus(250, 0, 0, 1);
    applyStimulus(251, 0, 0, 0);

    // Repeated lock loss during SDRAM_WAIT until the counter saturates.
    p   = 373;
    llc = 8'd2;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(p, 0, 1, 0);
      expectEvent(p + 16, 0, 1, 1, 0, llc);
      expectEvent(p + 21, 0, 0, 1, 0, llc);
      applyStimulus(p + 21, 0, 0, 0);
      if (llc != 8'd255) llc = llc + 8'd1;
      expectEvent(p + 24, 1, 1, 1, 0, llc);
      p = p + 24;
    end

    // Asynchronous reset in SDRAM_WAIT: outputs return before the next clock edge.
    applyStimulus(p, 0, 1, 0);
    expectEvent(p + 16, 0, 1, 1, 0, 8'd255);
    expectEvent(p + 21, 0, 0, 1, 0, 8'd255);
    waitEdge(p + 30);
    expectEvent(p + 30, 1, 1, 1, 0, 8'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expectEvent(16, 0, 1, 1, 0, 8'd0);
    expectEvent(21, 0, 0, 1, 0, 8'd0);
    expectEvent(53, 0, 0, 0, 1, 8'd0);
    waitEdge(60);

    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("[TB] FAIL missing_events: got %0d events never observed, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
